// File: rtl/gpio_ctrl.sv
// Register-access controller for the GPIO pin block: shadow MODE/DATA, synchronised IN,
// write-1-to-clear EDGE, and a round-robin arbiter between the CPU bus (port 0) and UART (port 1).
module gpio_ctrl #(
    parameter int          WIDTH_PIN = 2,
    parameter logic [31:0] MODE_RST  = 32'h0,
    parameter logic [31:0] DATA_RST  = 32'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [3:0]  req_addr,
    input  logic [63:0] req_wdata,
    input  logic [63:0] req_wmask,
    output logic [1:0]  ack,
    output logic [31:0] rdata,
    output logic [31:0] gpio_mode,
    output logic [31:0] gpio_data,
    output logic        gpio_valid,
    input  logic [31:0] gpio_in
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state;
    logic                 sel, last, wr_q;
    logic [1:0]           addr_q;
    logic [31:0]          wdata_q, wmask_q;
    logic [31:0]          mode_q, data_q;
    logic [WIDTH_PIN-1:0] s1, s2, s3, edge_q;
    logic [WIDTH_PIN-1:0] edge_set, edge_clr;
    logic [1:0]           arm;
    logic                 grant;
    logic [31:0]          in_ext, edge_ext, w1c, cur_val, new_val;
    logic                 unused_in;

    assign gpio_mode = mode_q;
    assign gpio_data = data_q;
    assign unused_in = ^gpio_in;

    // Round-robin: on a tie the port that did not win last time gets the grant.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11)
            grant = ~last;
        else if (req_valid[1])
            grant = 1'b1;
    end

    always_comb begin
        in_ext                      = '0;
        in_ext[WIDTH_PIN-1:0]       = s2;
        edge_ext                    = '0;
        edge_ext[WIDTH_PIN-1:0]     = edge_q;
        w1c                         = wdata_q & wmask_q;
        case (addr_q)
            2'd0:    cur_val = mode_q;
            2'd1:    cur_val = data_q;
            2'd2:    cur_val = in_ext;
            default: cur_val = edge_ext;
        endcase
        new_val = (cur_val & ~wmask_q) | w1c;
    end

    assign edge_set = (arm == 2'd3) ? (s2 ^ s3) : '0;
    assign edge_clr = (state == ACCESS && wr_q && addr_q == 2'd3) ? w1c[WIDTH_PIN-1:0] : '0;

    // Input path; edges are suppressed until the synchroniser has flushed its reset zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            edge_q <= '0;
            arm    <= 2'd0;
        end else begin
            s1     <= gpio_in[WIDTH_PIN-1:0];
            s2     <= s1;
            s3     <= s2;
            edge_q <= (edge_q & ~edge_clr) | edge_set;
            if (arm != 2'd3)
                arm <= arm + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            sel        <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 2'd0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            mode_q     <= MODE_RST;
            data_q     <= DATA_RST;
            ack        <= 2'b00;
            rdata      <= '0;
            gpio_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        sel     <= grant;
                        last    <= grant;
                        wr_q    <= grant ? req_write[1]     : req_write[0];
                        addr_q  <= grant ? req_addr[3:2]    : req_addr[1:0];
                        wdata_q <= grant ? req_wdata[63:32] : req_wdata[31:0];
                        wmask_q <= grant ? req_wmask[63:32] : req_wmask[31:0];
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    ack        <= sel ? 2'b10 : 2'b01;
                    rdata      <= wr_q ? '0 : cur_val;
                    gpio_valid <= 1'b0;
                    if (wr_q && addr_q == 2'd0) begin
                        mode_q     <= new_val;
                        gpio_valid <= (new_val != cur_val);
                    end
                    if (wr_q && addr_q == 2'd1) begin
                        data_q     <= new_val;
                        gpio_valid <= (new_val != cur_val);
                    end
                    state <= RESP;
                end
                RESP: begin
                    ack        <= 2'b00;
                    rdata      <= '0;
                    gpio_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Register-access controller and two-port arbiter for the GPIO pin block. It holds the shadow MODE/DATA registers and pushes updates into the GPIO block with a one-cycle `valid` strobe. It synchronises the GPIO read-back into an input register and latches per-pin edge events. Two requesters (CPU bus port 0, UART command port 1) share it under round-robin arbitration.

## Interface
- `WIDTH_PIN`, 2, number of physical pins; IN/EDGE bits at and above `WIDTH_PIN` read 0.
- `MODE_RST`, 32'h0, reset value of MODE (1 = drive, 0 = read).
- `DATA_RST`, 32'd3, reset value of DATA; matches the GPIO block's power-up value.
- `clk` input 1: sole clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 2: request per port (bit p = port p).
- `req_write` input 2: 1 = write, 0 = read, per port.
- `req_addr` input 4: 2 bits per port, port p at [2p+1:2p]. 0 = MODE, 1 = DATA, 2 = IN, 3 = EDGE.
- `req_wdata` input 64: 32 bits per port, port p at [32p+31:32p].
- `req_wmask` input 64: per-bit write enable, same packing as `req_wdata`.
- `ack` output 2: one-cycle completion pulse to the served port.
- `rdata` output 32: read data, valid only in the cycle `ack` is high; 0 otherwise.
- `gpio_mode` output 32: to GPIO `mode`.
- `gpio_data` output 32: to GPIO `data`.
- `gpio_valid` output 1: to GPIO `valid`; one-cycle load strobe.
- `gpio_in` input 32: from GPIO `data_o`; asynchronous to `clk`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS when any `req_valid` bit is set; winner latched (`sel`) together with its write/addr/wdata/wmask.
  - ACCESS → RESP unconditionally; register update performed here.
  - RESP → IDLE unconditionally; `ack[sel]` = 1 and `rdata` driven.
- Arbitration: `last` pointer, reset value 1, so port 0 wins first.
  - Both requesting: grant the port ≠ `last`.
  - One requesting: grant it.
  - `last` ← `sel` on entry to ACCESS.
- Masked write to MODE/DATA: new = (old & ~wmask) | (wdata & wmask).
  - `gpio_valid` pulses in RESP only if the written register changed value.
- IN is read-only; writes are ignored but still acked.
- EDGE is write-1-to-clear: bits with wdata&wmask = 1 clear.
  - A new edge on the same bit in the same cycle as its clear: set wins.
- Reads return the register value as of ACCESS. A MODE/DATA read returns the shadow value.
- Input path:
  - Two-flop synchroniser `s1`, `s2`, then history flop `s3`, all on `gpio_in[WIDTH_PIN-1:0]`.
  - IN = `s2`.
  - Edge event when `s2` ≠ `s3`; sets the EDGE bit.
- Arming: a 2-bit counter counts 3 cycles after reset release; edge events are ignored until it saturates. Prevents spurious edges from the reset-to-0 synchroniser.
- Requester rule: hold `req_*` stable until `ack`, then drop `req_valid` the next cycle. A request still high in the cycle after `ack` is a new transaction.

## Timing
- Reset values:
  - `ack` = 0, `rdata` = 0, `gpio_valid` = 0.
  - `gpio_mode` = `MODE_RST`, `gpio_data` = `DATA_RST`.
  - IN = 0, EDGE = 0, FSM = IDLE, `last` = 1, arm counter = 0.
- Latency: request seen in IDLE at cycle N → ACCESS at N+1 → `ack` and `gpio_valid` at N+2 → IDLE at N+3.
- Throughput: one transaction per 3 cycles. A losing port waits at most one transaction.
- `gpio_mode`/`gpio_data` change at the clock that enters RESP and are stable while `gpio_valid` = 1.
- Pin-to-IN latency: 2 cycles. Pin-to-EDGE latency: 3 cycles.
- Reset mid-transaction: everything returns to reset values immediately; no `ack` is emitted; a pending update is discarded.

## Test plan
- Reset, then read MODE/DATA/IN/EDGE from port 0 → 0, 3, 0, 0. Each `ack` arrives 2 cycles after the request. `gpio_valid` never pulses.
- Port 0 writes DATA with wdata = 32'h1, wmask = 32'h2 → DATA = 32'h1 and `gpio_data` = 1 at `ack`. `gpio_valid` is high for exactly that cycle.
- Port 0 repeats the same write → `ack` returns; `gpio_valid` stays 0.
- Both ports request on the same cycle, twice back-to-back → grant order 0, 1, 0, 1; `ack` pulses 3 cycles apart.
- Drive `gpio_in[1]` 0→1 after arming → IN[1] = 1 after 2 cycles and EDGE = 32'h2 after 3 cycles. A W1C write of 32'h2 clears EDGE to 0.
- Hold `gpio_in` = 3 through reset release → EDGE stays 0. Assert `rst` during ACCESS of a MODE write → MODE = 0, no `ack`, no `gpio_valid`.
